// File: rtl/mac_pkg.sv
// mac_pkg: shared types for the MAC operand sequencer.
// State encoding and accumulator width helper.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } mac_seq_state_t;

  function automatic int MAC_ACC_W(input int dw);
    return 3 * dw;
  endfunction

endpackage

// File: rtl/mac_operand_sequencer_if.sv
// mac_operand_sequencer_if: FIFO, MAC and result bundle.
// master = sequencer side, slave = surrounding lane.
interface mac_operand_sequencer_if #(
  parameter int DW = 8
);
  import mac_pkg::*;

  localparam int AW = MAC_ACC_W(DW);

  logic          start;
  logic          busy;
  logic          done;
  logic          a_rd_en;
  logic          a_empty;
  logic [DW-1:0] a_data;
  logic          b_rd_en;
  logic          b_empty;
  logic [DW-1:0] b_data;
  logic          mac_en;
  logic          mac_clr;
  logic [DW-1:0] mac_ain;
  logic [DW-1:0] mac_bin;
  logic [AW-1:0] mac_cout;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;

  modport master (
    input  start, a_empty, a_data,
    input  b_empty, b_data,
    input  mac_cout, res_ready,
    output busy, done,
    output a_rd_en, b_rd_en,
    output mac_en, mac_clr,
    output mac_ain, mac_bin,
    output res_valid, res_data
  );

  modport slave (
    output start, a_empty, a_data,
    output b_empty, b_data,
    output mac_cout, res_ready,
    input  busy, done,
    input  a_rd_en, b_rd_en,
    input  mac_en, mac_clr,
    input  mac_ain, mac_bin,
    input  res_valid, res_data
  );

endinterface

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: pops paired operands into one MAC lane.
// Optional stall counter port: define MAC_SEQ_STALL_CNT_EN.
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LEN    = 8
) (
  input  logic clk,
  input  logic rst_n,
  mac_operand_sequencer_if.master bus
`ifdef MAC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int AW = MAC_ACC_W(DATA_WIDTH);

  localparam logic [CW-1:0] FULL = CW'(VEC_LEN);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_CLEAR  = CLEAR;
  localparam logic [2:0] S_STREAM = STREAM;
  localparam logic [2:0] S_DRAIN  = DRAIN;
  localparam logic [2:0] S_RESULT = RESULT;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic          drain_q, drain_d;
  logic          en_q;
  logic [AW-1:0] res_q, res_d;

  logic st_idle, st_clear, st_stream;
  logic st_drain, st_result;
  logic pop, last_pop;

  assign st_idle   = (state_q == S_IDLE);
  assign st_clear  = (state_q == S_CLEAR);
  assign st_stream = (state_q == S_STREAM);
  assign st_drain  = (state_q == S_DRAIN);
  assign st_result = (state_q == S_RESULT);

  assign pop = st_stream
             && !bus.a_empty
             && !bus.b_empty
             && (issued_q < FULL);

  assign last_pop = pop && (issued_q == LAST);

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_idle:   if (bus.start) state_d = S_CLEAR;
      st_clear:  state_d = S_STREAM;
      st_stream: if (last_pop) state_d = S_DRAIN;
      st_drain:  if (drain_q) state_d = S_RESULT;
      st_result: if (bus.res_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // pop counter, 2-cycle drain timer, result capture
  always_comb begin
    issued_d = issued_q;
    if (st_clear) begin
      issued_d = '0;
    end else if (pop) begin
      issued_d = issued_q + CW'(1);
    end
    drain_d = st_drain && !drain_q;
    res_d   = res_q;
    if (st_drain && drain_q) begin
      res_d = bus.mac_cout;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      issued_q <= '0;
      drain_q  <= 1'b0;
      en_q     <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      drain_q  <= drain_d;
      en_q     <= pop;
      res_q    <= res_d;
    end
  end

  // operands are gated by En so the MAC inputs read 0 when idle
  assign bus.a_rd_en   = pop;
  assign bus.b_rd_en   = pop;
  assign bus.mac_en    = en_q;
  assign bus.mac_clr   = st_clear;
  assign bus.mac_ain   = en_q ? bus.a_data : '0;
  assign bus.mac_bin   = en_q ? bus.b_data : '0;
  assign bus.busy      = !st_idle;
  assign bus.res_valid = st_result;
  assign bus.res_data  = res_q;
  assign bus.done      = st_result && bus.res_ready;

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // saturating count of starved STREAM cycles
  always_comb begin
    stall_d = stall_q;
    if (st_clear) begin
      stall_d = '0;
    end else if (st_stream && !pop
                 && (issued_q < FULL)
                 && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: FIFO + MAC environment model.
// Checks timing, results, stalls, backpressure and reset.
module tb_mac_operand_sequencer;
  import mac_pkg::*;

  localparam int DW = 8;
  localparam int VL = 8;
  localparam int AW = 3 * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_operand_sequencer_if #(.DW(DW)) bus();

`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  mac_operand_sequencer #(
    .DATA_WIDTH(DW),
    .VEC_LEN(VL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: 1-cycle read latency, pointer based
  logic [DW-1:0] amem [256];
  logic [DW-1:0] bmem [256];
  int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;
  logic [DW-1:0] a_dr = '0, b_dr = '0;
  bit b_gate = 1'b0;

  assign bus.a_empty = (a_wr == a_rd);
  assign bus.b_empty = (b_wr == b_rd) || b_gate;
  assign bus.a_data  = a_dr;
  assign bus.b_data  = b_dr;

  always @(posedge clk) begin
    if (bus.a_rd_en) begin
      a_dr <= amem[a_rd % 256];
      a_rd <= a_rd + 1;
    end
    if (bus.b_rd_en) begin
      b_dr <= bmem[b_rd % 256];
      b_rd <= b_rd + 1;
    end
  end

  // MAC model: registered accumulate, not reset by rst_n
  logic [AW-1:0] acc = '0;
  assign bus.mac_cout = acc;
  always @(posedge clk) begin
    if (bus.mac_clr) acc <= '0;
    else if (bus.mac_en) acc <= acc + bus.mac_ain * bus.mac_bin;
  end

  // protocol monitor: paired pops, no pop on empty,
  // En one cycle after each pop, operands match FIFO data
  bit prev_pop = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_pop = 1'b0;
    end else begin
      if (bus.a_rd_en !== bus.b_rd_en) viol++;
      if (bus.a_rd_en && (bus.a_empty || bus.b_empty)) viol++;
      if (bus.mac_en !== prev_pop) viol++;
      if (bus.mac_en &&
          (bus.mac_ain !== a_dr || bus.mac_bin !== b_dr)) viol++;
      prev_pop = bus.a_rd_en;
    end
  end

  int c0, lv, ld, clr, np, ne;
  logic [AW-1:0] rdat;
  bit uns, rpop, nb, bafter, dafter, to;
  logic [AW-1:0] expd;

  task automatic flush();
    a_wr = a_rd;
    b_wr = b_rd;
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
    amem[a_wr % 256] = a;
    bmem[b_wr % 256] = b;
    a_wr++;
    b_wr++;
  endtask

  // loads one vector pair and returns the dot product
  task automatic load(input int mode, output logic [AW-1:0] e);
    int s = 0;
    for (int i = 0; i < VL; i++) begin
      int a, b;
      unique case (mode)
        0: begin a = i + 1; b = 1; end
        1: begin a = 255; b = 255; end
        3: begin a = 2; b = 3; end
        default: begin
          a = $urandom_range(0, 255);
          b = $urandom_range(0, 255);
        end
      endcase
      push(DW'(a), DW'(b));
      s += a * b;
    end
    e = AW'(s);
  endtask

  // spec timing: pops from cycle 2, gated cycles skip a pop
  function automatic int exp_valid(input int gs, input int ge);
    int c = 2;
    int n = 0;
    while (n < VL) begin
      if (!(c >= gs && c <= ge)) n++;
      c++;
    end
    return (c - 1) + 3;
  endfunction

  task automatic do_op(
    input int gs, input int ge, input int rdy_at,
    input int sp1, input int sp2, input bit chain
  );
    int lat;
    if (!bus.start) begin
      @(negedge clk);
      bus.start = 1'b1;
    end
    c0 = cyc;
    bus.res_ready = (rdy_at <= 0);
    lv = -1; ld = -1; clr = -1; np = 0; ne = 0;
    rdat = '0; uns = 0; rpop = 0; nb = 0; to = 0;
    for (int k = 0; k < 400 && ld < 0; k++) begin
      @(negedge clk);
      lat = cyc - c0;
      bus.start = (lat == sp1) || (lat == sp2);
      b_gate = (lat >= gs) && (lat <= ge);
      if (lat >= rdy_at) bus.res_ready = 1'b1;
      #1;
      if (bus.mac_clr && clr < 0) clr = lat;
      if (bus.a_rd_en) np++;
      if (bus.mac_en) ne++;
      if (bus.res_valid) begin
        if (lv < 0) begin
          lv = lat;
          rdat = bus.res_data;
        end else if (bus.res_data !== rdat) begin
          uns = 1;
        end
        if (bus.a_rd_en) rpop = 1;
        if (!bus.busy) nb = 1;
      end
      if (bus.done) ld = lat;
    end
    if (ld < 0) to = 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.res_ready = 1'b0;
    b_gate = 1'b0;
    #1;
    bafter = bus.busy;
    dafter = bus.done;
    bus.start = chain;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    ncmp++;
    if ({bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en,
         bus.mac_en, bus.mac_clr, bus.res_valid} !== 7'd0) begin
      nerr++;
      $display("FAIL reset_ctrl got %b want 0",
               {bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en,
                bus.mac_en, bus.mac_clr, bus.res_valid});
    end
    ncmp++;
    if ({bus.res_data, bus.mac_ain, bus.mac_bin} !== '0) begin
      nerr++;
      $display("FAIL reset_data got %0h want 0", bus.res_data);
    end
`ifdef MAC_SEQ_STALL_CNT_EN
    ncmp++;
    if (stall_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL reset_stall got %0d want 0", stall_cnt);
    end
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    ncmp++;
    if (bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL idle_no_start busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    load(0, expd);
    do_op(999, 0, 0, -1, -1, 0);
    ncmp++;
    if (to !== 1'b0) begin
      nerr++; $display("FAIL basic_timeout got 1 want 0");
    end
    ncmp++;
    if (clr !== 1) begin
      nerr++; $display("FAIL basic_clr_cycle got %0d want 1", clr);
    end
    ncmp++;
    if (lv !== VL + 4) begin
      nerr++; $display("FAIL basic_valid_cycle got %0d want %0d", lv, VL + 4);
    end
    ncmp++;
    if (ld !== VL + 4) begin
      nerr++; $display("FAIL basic_done_cycle got %0d want %0d", ld, VL + 4);
    end
    ncmp++;
    if (rdat !== 24'd36 || rdat !== expd) begin
      nerr++; $display("FAIL basic_result got %0d want %0d", rdat, expd);
    end
    ncmp++;
    if (np !== VL || ne !== VL) begin
      nerr++; $display("FAIL basic_pops got %0d/%0d want %0d", np, ne, VL);
    end
    ncmp++;
    if (bafter !== 1'b0 || dafter !== 1'b0) begin
      nerr++; $display("FAIL basic_after got %b%b want 00", bafter, dafter);
    end
  endtask

  task automatic test_max();
    load(1, expd);
    do_op(999, 0, 0, -1, -1, 0);
    ncmp++;
    if (rdat !== 24'h07F008 || rdat !== expd) begin
      nerr++; $display("FAIL max_result got %0h want %0h", rdat, expd);
    end
    ncmp++;
    if (lv !== VL + 4 || to) begin
      nerr++; $display("FAIL max_valid_cycle got %0d want %0d", lv, VL + 4);
    end
  endtask

  task automatic test_stall();
    load(2, expd);
    do_op(4, 6, 0, -1, -1, 0);
    ncmp++;
    if (lv !== exp_valid(4, 6) || lv !== 15) begin
      nerr++; $display("FAIL stall_valid_cycle got %0d want 15", lv);
    end
    ncmp++;
    if (rdat !== expd) begin
      nerr++; $display("FAIL stall_result got %0d want %0d", rdat, expd);
    end
    ncmp++;
    if (np !== VL || ne !== VL) begin
      nerr++; $display("FAIL stall_pops got %0d/%0d want %0d", np, ne, VL);
    end
`ifdef MAC_SEQ_STALL_CNT_EN
    ncmp++;
    if (stall_cnt !== 16'd3) begin
      nerr++; $display("FAIL stall_cnt got %0d want 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    load(2, expd);
    do_op(999, 0, VL + 9, -1, -1, 0);
    ncmp++;
    if (lv !== VL + 4 || ld !== VL + 9) begin
      nerr++;
      $display("FAIL bp_cycles got %0d/%0d want %0d/%0d",
               lv, ld, VL + 4, VL + 9);
    end
    ncmp++;
    if ({uns, rpop, nb} !== 3'b000) begin
      nerr++; $display("FAIL bp_hold got %b want 000", {uns, rpop, nb});
    end
    ncmp++;
    if (rdat !== expd || bus.res_data !== expd) begin
      nerr++; $display("FAIL bp_result got %0d want %0d", rdat, expd);
    end
    ncmp++;
    if (bafter !== 1'b0) begin
      nerr++; $display("FAIL bp_busy_after got 1 want 0");
    end
  endtask

  task automatic test_ignored_start();
    load(2, expd);
    do_op(999, 0, VL + 6, 5, VL + 5, 0);
    ncmp++;
    if (np !== VL || ne !== VL || lv !== VL + 4 || ld !== VL + 6) begin
      nerr++;
      $display("FAIL ign_start got np=%0d lv=%0d ld=%0d want %0d/%0d/%0d",
               np, lv, ld, VL, VL + 4, VL + 6);
    end
    ncmp++;
    if (rdat !== expd || bafter !== 1'b0) begin
      nerr++; $display("FAIL ign_start_result got %0d want %0d", rdat, expd);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] e1, e2, r1;
    int ca;
    load(2, e1);
    load(2, e2);
    do_op(999, 0, 0, -1, -1, 1);
    ca = c0;
    r1 = rdat;
    do_op(999, 0, 0, -1, -1, 0);
    ncmp++;
    if (r1 !== e1 || rdat !== e2) begin
      nerr++;
      $display("FAIL b2b_result got %0d,%0d want %0d,%0d", r1, rdat, e1, e2);
    end
    ncmp++;
    if (c0 - ca !== VL + 5 || lv !== VL + 4) begin
      nerr++;
      $display("FAIL b2b_period got %0d want %0d", c0 - ca, VL + 5);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int gs, ge, ra, el, ed;
      gs = $urandom_range(2, 10);
      ge = ($urandom_range(0, 3) == 0) ? 0 : gs + $urandom_range(0, 3);
      ra = $urandom_range(0, 20);
      el = exp_valid(gs, ge);
      ed = (ra > el) ? ra : el;
      load(2, expd);
      do_op(gs, ge, ra, $urandom_range(2, 9), -1, 0);
      ncmp++;
      if (rdat !== expd || lv !== el || ld !== ed || np !== VL) begin
        nerr++;
        $display("FAIL rand_%0d got r=%0d lv=%0d ld=%0d want %0d/%0d/%0d",
                 it, rdat, lv, ld, expd, el, ed);
      end
`ifdef MAC_SEQ_STALL_CNT_EN
      ncmp++;
      if (stall_cnt !== 16'(el - (VL + 4))) begin
        nerr++;
        $display("FAIL rand_stall_%0d got %0d want %0d",
                 it, stall_cnt, el - (VL + 4));
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit popped = 0;
    load(2, expd);
    @(negedge clk);
    bus.start = 1'b1;
    for (int k = 0; k < 50 && n < 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.a_rd_en) n++;
    end
    rst_n = 1'b0;
    #1;
    ncmp++;
    if ({bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en,
         bus.mac_en, bus.mac_clr, bus.res_valid} !== 7'd0 ||
        {bus.res_data, bus.mac_ain, bus.mac_bin} !== '0 || n != 4) begin
      nerr++;
      $display("FAIL rst_mid_async got busy=%b pop=%b en=%b n=%0d want 0",
               bus.busy, bus.a_rd_en, bus.mac_en, n);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      if (bus.a_rd_en || bus.b_rd_en) popped = 1;
    end
    ncmp++;
    if (popped !== 1'b0) begin
      nerr++; $display("FAIL rst_mid_pops got 1 want 0");
    end
    flush();
    rst_n = 1'b1;
    load(3, expd);
    do_op(999, 0, 0, -1, -1, 0);
    ncmp++;
    if (rdat !== 24'd48 || rdat !== expd || to) begin
      nerr++; $display("FAIL rst_mid_result got %0d want 48", rdat);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (3) @(negedge clk);
    ncmp++;
    if (viol !== 0) begin
      nerr++; $display("FAIL protocol got %0d violations want 0", viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
